psg_env_sequencer: RTL and testbench
====================================

// Module: psg_env_sequencer
// PURPOSE
//  Hardware volume-envelope sequencer for the 16-channel PSG. Sits between the CPU register
//  port and the PSG attribute write port: forwards CPU attribute writes and, once per
//  next_sample, ramps each enabled channel's volume toward a target by rewriting attribute byte 2.
//  CPU writes always win the shared port; envelope writes are deferred until the port is free.
// PARAMETERS
//  NUM_CH    16  channels scanned per sample (attribute address = {ch[3:0], byte[1:0]})
//  RATE_W     8  width of per-channel step period (in samples)
// PORTS
//  clk            in   1  system clock; sole clock domain
//  rst_n          in   1  reset, synchronous, active-low
//  cpu_addr       in   6  CPU attribute address {ch,byte}
//  cpu_wrdata     in   8  CPU attribute write data
//  cpu_write      in   1  CPU attribute write strobe (1 cycle)
//  env_addr       in   5  {ch[3:0], sel}: sel=0 -> {en,1'b0,target[5:0]}, sel=1 -> rate[7:0]
//  env_wrdata     in   8  envelope config write data
//  env_write      in   1  envelope config write strobe
//  next_sample    in   1  sample tick (same strobe the PSG consumes)
//  attr_addr      out  6  to PSG attr_addr
//  attr_wrdata    out  8  to PSG attr_wrdata
//  attr_write     out  1  to PSG attr_write
//  env_busy       out  1  scan in progress (state != IDLE)
//  env_overrun    out  1  sticky: next_sample arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0; per-channel cur_vol, target, rate, cnt, en,
//   lr_shadow = 0; FSM -> IDLE; pending write cleared. Reset mid-scan aborts with no further writes.
//  Output port is registered: attr_* valid 1 cycle after the decision; attr_write high 1 cycle.
//  CPU path: cpu_write at cycle N -> attr_write at N+1 with cpu_addr/cpu_wrdata unchanged.
//   If cpu_addr[1:0]==2: lr_shadow[ch]<=wrdata[7:6], cur_vol[ch]<=wrdata[5:0], cnt[ch]<=rate[ch].
//  Envelope config writes update en/target/rate only; cnt unchanged; take effect at next visit.
//  FSM: IDLE --next_sample--> SCAN(ch=0). SCAN visits one channel/cycle:
//   - visit: if en && cur_vol!=target: if cnt==0 {cnt<=rate; cur_vol +-=1 toward target;
//     raise pending write {ch,2'd2},{lr_shadow,new_vol}} else cnt<=cnt-1. Otherwise no action.
//   - pending write + cpu_write same cycle -> SCAN -> WAIT (hold ch, pending); else issue, advance.
//   - WAIT: issue pending on first cycle with cpu_write=0, then resume SCAN at ch+1.
//   - after ch=NUM_CH-1 issued/skipped -> IDLE.
//  rate=0: step every sample. target reached: no writes, cnt frozen. en=0: channel untouched.
//  Volume arithmetic unsigned 6-bit, saturates by construction (steps stop at target; no wrap).
//  Collision: CPU write to byte 2 of the channel holding a pending envelope write drops the
//   pending write (CPU value wins); scan continues at ch+1.
//  next_sample while busy: ignored, env_overrun<=1. next_sample and cpu_write same cycle: both
//   honoured (CPU forwarded, scan starts).
//  Minimum scan: NUM_CH cycles; each CPU collision adds 1 cycle.
// STRUCTURE
//  Shared package psg_pkg: PSG_NUM_CH, PSG_ATTR_BYTES=4, PSG_VOL_BYTE=2, ENV_SEL_TARGET/RATE,
//   env FSM state encoding (IDLE, SCAN, WAIT).
//  Sub-module psg_env_chan_step: combinational next {cur_vol, cnt, do_write} for one channel;
//   top holds per-channel regs, FSM, and port mux/arbiter.
// TESTING
//  1 Reset: drive rst_n=0 2 cycles mid-scan -> attr_write=0, env_busy=0, env_overrun=0 after.
//  2 CPU passthrough: cpu_write addr=0x09 data=0xC5 -> next cycle attr_addr=0x09, wrdata=0xC5.
//  3 Ramp up: ch3 byte2=0xC0, target=4, rate=1, en=1; 10 next_samples -> writes 0x0E=0xC1,
//    0xC2,0xC3,0xC4 on samples 2,4,6,8; none after.
//  4 Ramp down rate=0: ch0 vol=10, target=7 -> writes 9,8,7 on 3 consecutive samples, lr kept.
//  5 Collision: pending env write ch5 and cpu_write to 0x20 same cycle -> CPU first, env write
//    one cycle later; CPU write to 0x16 instead -> env write to ch5 dropped, cur_vol=CPU value.
//  6 Overrun: next_sample twice 5 cycles apart -> second ignored, env_overrun=1 and stays 1.

Source files
------------

// File: rtl/psg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psg_pkg
//  Description : Shared constants and types for the PSG envelope sequencer.
//                This file defines the attribute address layout, the
//                envelope config select codes and the sequencer state
//                encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package psg_pkg;

    localparam int PSG_NUM_CH     = 16;
    localparam int PSG_ATTR_BYTES = 4;
    // Attribute address is {ch, byte}.
    localparam int PSG_ADDR_W     = $clog2(PSG_NUM_CH * PSG_ATTR_BYTES);
    localparam int PSG_VOL_W      = 6;

    // Attribute byte 2 holds {lr[1:0], vol[5:0]}.
    localparam logic [1:0] PSG_VOL_BYTE = 2'd2;

    // Envelope config select (env_addr[0]).
    localparam logic ENV_SEL_TARGET = 1'b0;
    localparam logic ENV_SEL_RATE   = 1'b1;

    typedef enum logic [1:0] {
        ENV_IDLE = 2'd0,
        ENV_SCAN = 2'd1,
        ENV_WAIT = 2'd2
    } env_state_e;

endpackage
`default_nettype wire

// File: rtl/psg_env_chan_step.sv
`default_nettype none
// ============================================================================
//  Module      : psg_env_chan_step
//  Description : Computes one envelope step for a single channel. This is
//                purely combinational logic. When the channel is enabled
//                and is not yet at its target, the module does one of two
//                things:
//                  - It counts the step-period counter down.
//                  - When the counter has expired, it reloads the counter
//                    and moves the volume one unit toward the target.
//  Ports       : en_i        channel envelope enable
//                cur_vol_i   current volume
//                target_i    target volume
//                rate_i      step period reload value
//                cnt_i       current step-period counter
//                nxt_vol_o   volume after this visit
//                nxt_cnt_o   counter after this visit
//                do_write_o  a volume write must be issued to the PSG
//  Revision    : 1.0 - initial release
// ============================================================================
module psg_env_chan_step
    import psg_pkg::*;
#(
    parameter int RATE_W = 8
) (
    input  logic                 en_i,
    input  logic [PSG_VOL_W-1:0] cur_vol_i,
    input  logic [PSG_VOL_W-1:0] target_i,
    input  logic [RATE_W-1:0]    rate_i,
    input  logic [RATE_W-1:0]    cnt_i,
    output logic [PSG_VOL_W-1:0] nxt_vol_o,
    output logic [RATE_W-1:0]    nxt_cnt_o,
    output logic                 do_write_o
);

    always_comb begin
        nxt_vol_o  = cur_vol_i;
        nxt_cnt_o  = cnt_i;
        do_write_o = 1'b0;
        // The channel is left frozen (counter included) once it has
        // reached its target. Stepping stops at the target, so the
        // volume can never wrap.
        if (en_i && (cur_vol_i != target_i)) begin
            if (cnt_i == '0) begin
                nxt_cnt_o  = rate_i;
                do_write_o = 1'b1;
                if (target_i > cur_vol_i) begin
                    nxt_vol_o = cur_vol_i + 1'b1;
                end else begin
                    nxt_vol_o = cur_vol_i - 1'b1;
                end
            end else begin
                nxt_cnt_o = cnt_i - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psg_env_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : psg_env_sequencer
//  Description : Hardware volume-envelope sequencer for the 16-channel PSG.
//                It forwards CPU attribute writes to the PSG. On every
//                sample tick it scans all channels and ramps each enabled
//                channel's volume toward its target by rewriting attribute
//                byte 2. CPU writes always win the shared port.
//  Ports       : clk_i          system clock
//                rst_n_i        synchronous active-low reset
//                cpu_addr_i     CPU attribute address {ch,byte}
//                cpu_wrdata_i   CPU attribute write data
//                cpu_write_i    CPU attribute write strobe
//                env_addr_i     {ch, sel} envelope config address
//                env_wrdata_i   envelope config data
//                env_write_i    envelope config write strobe
//                next_sample_i  sample tick
//                attr_addr_o    PSG attribute address (registered)
//                attr_wrdata_o  PSG attribute data (registered)
//                attr_write_o   PSG attribute write strobe (registered)
//                env_busy_o     scan in progress
//                env_overrun_o  sticky: sample tick arrived while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module psg_env_sequencer
    import psg_pkg::*;
#(
    parameter int NUM_CH = PSG_NUM_CH,
    parameter int RATE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [PSG_ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]            cpu_wrdata_i,
    input  logic                  cpu_write_i,
    input  logic [4:0]            env_addr_i,
    input  logic [7:0]            env_wrdata_i,
    input  logic                  env_write_i,
    input  logic                  next_sample_i,
    output logic [PSG_ADDR_W-1:0] attr_addr_o,
    output logic [7:0]            attr_wrdata_o,
    output logic                  attr_write_o,
    output logic                  env_busy_o,
    output logic                  env_overrun_o
);

    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    // Per-channel state
    logic [PSG_VOL_W-1:0] cur_vol_q [NUM_CH];
    logic [PSG_VOL_W-1:0] target_q  [NUM_CH];
    logic [RATE_W-1:0]    rate_q    [NUM_CH];
    logic [RATE_W-1:0]    cnt_q     [NUM_CH];
    logic [1:0]           lr_q      [NUM_CH];
    logic [NUM_CH-1:0]    en_q;

    // Scan control
    env_state_e           state_q, state_d;
    logic [3:0]           ch_q, ch_d;
    logic [7:0]           pend_data_q, pend_data_d;
    logic                 overrun_q, overrun_d;

    // Output port
    logic [PSG_ADDR_W-1:0] attr_addr_q, attr_addr_d;
    logic [7:0]            attr_data_q, attr_data_d;
    logic                  attr_write_q, attr_write_d;

    logic [PSG_VOL_W-1:0] w_step_vol;
    logic [RATE_W-1:0]    w_step_cnt;
    logic                 w_step_wr;
    logic                 w_visit;
    logic                 w_cpu_vol;
    logic                 w_cpu_hit;
    logic [3:0]           w_cpu_ch;
    logic [3:0]           w_env_ch;
    logic                 w_unused;

    assign w_visit   = (state_q == ENV_SCAN);
    assign w_cpu_ch  = cpu_addr_i[PSG_ADDR_W-1:2];
    assign w_env_ch  = env_addr_i[4:1];
    assign w_cpu_vol = cpu_write_i && (cpu_addr_i[1:0] == PSG_VOL_BYTE);
    // A CPU write to the volume byte of the channel being processed
    // supersedes any envelope write for that channel.
    assign w_cpu_hit = w_cpu_vol && (w_cpu_ch == ch_q);
    assign w_unused  = env_wrdata_i[6];

    psg_env_chan_step #(
        .RATE_W     (RATE_W)
    ) u_step (
        .en_i       (en_q[ch_q]),
        .cur_vol_i  (cur_vol_q[ch_q]),
        .target_i   (target_q[ch_q]),
        .rate_i     (rate_q[ch_q]),
        .cnt_i      (cnt_q[ch_q]),
        .nxt_vol_o  (w_step_vol),
        .nxt_cnt_o  (w_step_cnt),
        .do_write_o (w_step_wr)
    );

    // ------------------------------------------------------------------
    // FSM next-state and port arbitration
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        pend_data_d  = pend_data_q;
        overrun_d    = overrun_q;
        attr_write_d = 1'b0;
        attr_addr_d  = cpu_addr_i;
        attr_data_d  = cpu_wrdata_i;

        // The CPU always owns the port in the cycle it writes.
        if (cpu_write_i) begin
            attr_write_d = 1'b1;
        end

        case (state_q)
            ENV_IDLE: begin
                if (next_sample_i) begin
                    state_d = ENV_SCAN;
                    ch_d    = 4'd0;
                end
            end
            ENV_SCAN: begin
                if (next_sample_i) begin
                    overrun_d = 1'b1;
                end
                if (w_step_wr && cpu_write_i && !w_cpu_hit) begin
                    // Port taken by an unrelated CPU write: park the
                    // envelope write and retry.
                    state_d     = ENV_WAIT;
                    pend_data_d = {lr_q[ch_q], w_step_vol};
                end else begin
                    if (w_step_wr && !cpu_write_i) begin
                        attr_write_d = 1'b1;
                        attr_addr_d  = {ch_q, PSG_VOL_BYTE};
                        attr_data_d  = {lr_q[ch_q], w_step_vol};
                    end
                    if (ch_q == LAST_CH) begin
                        state_d = ENV_IDLE;
                    end else begin
                        ch_d = ch_q + 4'd1;
                    end
                end
            end
            ENV_WAIT: begin
                if (next_sample_i) begin
                    overrun_d = 1'b1;
                end
                if (!cpu_write_i || w_cpu_hit) begin
                    // Issue the parked write. Drop it instead if the CPU
                    // has just rewritten the same volume byte.
                    if (!cpu_write_i) begin
                        attr_write_d = 1'b1;
                        attr_addr_d  = {ch_q, PSG_VOL_BYTE};
                        attr_data_d  = pend_data_q;
                    end
                    if (ch_q == LAST_CH) begin
                        state_d = ENV_IDLE;
                    end else begin
                        state_d = ENV_SCAN;
                        ch_d    = ch_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ENV_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ENV_IDLE;
            ch_q         <= 4'd0;
            pend_data_q  <= 8'd0;
            overrun_q    <= 1'b0;
            attr_write_q <= 1'b0;
            attr_addr_q  <= '0;
            attr_data_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            pend_data_q  <= pend_data_d;
            overrun_q    <= overrun_d;
            attr_write_q <= attr_write_d;
            attr_addr_q  <= attr_addr_d;
            attr_data_q  <= attr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel registers. The CPU volume write is applied last so that
    // it overrides an envelope step to the same channel in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_vol_q[i] <= '0;
                target_q[i]  <= '0;
                rate_q[i]    <= '0;
                cnt_q[i]     <= '0;
                lr_q[i]      <= 2'd0;
            end
            en_q <= '0;
        end else begin
            if (w_visit) begin
                cur_vol_q[ch_q] <= w_step_vol;
                cnt_q[ch_q]     <= w_step_cnt;
            end
            if (env_write_i) begin
                if (env_addr_i[0] == ENV_SEL_TARGET) begin
                    en_q[w_env_ch]     <= env_wrdata_i[7];
                    target_q[w_env_ch] <= env_wrdata_i[PSG_VOL_W-1:0];
                end else if (env_addr_i[0] == ENV_SEL_RATE) begin
                    rate_q[w_env_ch]   <= RATE_W'(env_wrdata_i);
                end
            end
            if (w_cpu_vol) begin
                lr_q[w_cpu_ch]      <= cpu_wrdata_i[7:6];
                cur_vol_q[w_cpu_ch] <= cpu_wrdata_i[PSG_VOL_W-1:0];
                cnt_q[w_cpu_ch]     <= rate_q[w_cpu_ch];
            end
        end
    end

    assign attr_addr_o   = attr_addr_q;
    assign attr_wrdata_o = attr_data_q;
    assign attr_write_o  = attr_write_q;
    assign env_busy_o    = (state_q != ENV_IDLE);
    assign env_overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_psg_env_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psg_env_sequencer
//  Description : Directed self-checking bench for psg_env_sequencer.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psg_env_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] cpu_addr;
    logic [7:0] cpu_wrdata;
    logic       cpu_write;
    logic [4:0] env_addr;
    logic [7:0] env_wrdata;
    logic       env_write;
    logic       next_sample;
    logic [5:0] attr_addr;
    logic [7:0] attr_wrdata;
    logic       attr_write;
    logic       env_busy;
    logic       env_overrun;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         wr_cnt = 0;
    logic [5:0] last_addr = '0;
    logic [7:0] last_data = '0;

    psg_env_sequencer u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cpu_addr_i    (cpu_addr),
        .cpu_wrdata_i  (cpu_wrdata),
        .cpu_write_i   (cpu_write),
        .env_addr_i    (env_addr),
        .env_wrdata_i  (env_wrdata),
        .env_write_i   (env_write),
        .next_sample_i (next_sample),
        .attr_addr_o   (attr_addr),
        .attr_wrdata_o (attr_wrdata),
        .attr_write_o  (attr_write),
        .env_busy_o    (env_busy),
        .env_overrun_o (env_overrun)
    );

    always #5 clk = ~clk;

    // Log every PSG write strobe.
    always @(negedge clk) begin
        if (attr_write === 1'b1) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = attr_addr;
            last_data = attr_wrdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
        cpu_addr   = a;
        cpu_wrdata = d;
        cpu_write  = 1'b1;
        tick();
        cpu_write  = 1'b0;
    endtask

    task automatic env_wr(input logic [4:0] a, input logic [7:0] d);
        env_addr   = a;
        env_wrdata = d;
        env_write  = 1'b1;
        tick();
        env_write  = 1'b0;
    endtask

    task automatic sample_run(input int n);
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        cpu_addr    = '0;
        cpu_wrdata  = '0;
        cpu_write   = 1'b0;
        env_addr    = '0;
        env_wrdata  = '0;
        env_write   = 1'b0;
        next_sample = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_write",   32'(attr_write),  32'd0);
        chk("rst_addr",    32'(attr_addr),   32'd0);
        chk("rst_data",    32'(attr_wrdata), 32'd0);
        chk("rst_busy",    32'(env_busy),    32'd0);
        chk("rst_overrun", 32'(env_overrun), 32'd0);

        // CPU passthrough
        cpu_wr(6'h09, 8'hC5);
        chk("pt_write", 32'(attr_write),  32'd1);
        chk("pt_addr",  32'(attr_addr),   32'h09);
        chk("pt_data",  32'(attr_wrdata), 32'hC5);
        tick();
        chk("pt_pulse", 32'(attr_write),  32'd0);

        // Ramp up: ch3, target 4, rate 1, start vol 0 with lr=3
        env_wr({4'd3, 1'b0}, 8'h84);
        env_wr({4'd3, 1'b1}, 8'h01);
        cpu_wr(6'h0E, 8'hC0);
        tick();
        for (int s = 1; s <= 10; s++) begin
            wr_cnt = 0;
            sample_run(20);
            if ((s % 2 == 0) && (s <= 8)) begin
                chk("up_cnt",  32'(wr_cnt),    32'd1);
                chk("up_addr", 32'(last_addr), 32'h0E);
                chk("up_data", 32'(last_data), 32'(8'hC0 + 8'(s / 2)));
            end else begin
                chk("up_none", 32'(wr_cnt), 32'd0);
            end
        end

        // Ramp down, rate 0: ch0 from 10 to 7, lr=2 preserved
        env_wr({4'd0, 1'b0}, 8'h87);
        env_wr({4'd0, 1'b1}, 8'h00);
        cpu_wr(6'h02, 8'h8A);
        tick();
        for (int s = 1; s <= 4; s++) begin
            wr_cnt = 0;
            sample_run(20);
            if (s <= 3) begin
                chk("dn_cnt",  32'(wr_cnt),    32'd1);
                chk("dn_addr", 32'(last_addr), 32'h02);
                chk("dn_data", 32'(last_data), 32'(8'h8A - 8'(s)));
            end else begin
                chk("dn_none", 32'(wr_cnt), 32'd0);
            end
        end

        // Collision: ch5 ramps up from 5 at rate 0. ch5 is visited at the
        // sixth edge after the edge that sees next_sample.
        env_wr({4'd5, 1'b0}, 8'h94);
        env_wr({4'd5, 1'b1}, 8'h00);
        cpu_wr(6'h16, 8'h05);
        tick();
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (5) tick();
        cpu_addr   = 6'h20;
        cpu_wrdata = 8'h55;
        cpu_write  = 1'b1;
        tick();
        cpu_write  = 1'b0;
        chk("col_cpu_addr", 32'(attr_addr),   32'h20);
        chk("col_cpu_data", 32'(attr_wrdata), 32'h55);
        tick();
        chk("col_env_wr",   32'(attr_write),  32'd1);
        chk("col_env_addr", 32'(attr_addr),   32'h16);
        chk("col_env_data", 32'(attr_wrdata), 32'h06);
        repeat (15) tick();

        // CPU hits the same volume byte: envelope write to ch5 is dropped.
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (5) tick();
        cpu_addr   = 6'h16;
        cpu_wrdata = 8'h4A;
        cpu_write  = 1'b1;
        tick();
        cpu_write  = 1'b0;
        chk("drop_cpu_data", 32'(attr_wrdata), 32'h4A);
        tick();
        chk("drop_no_env", 32'(attr_write), 32'd0);
        repeat (15) tick();

        // The next step continues from the CPU value (10 -> 11, lr=1).
        // The scan also lasts exactly 16 cycles.
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (6) tick();
        chk("resume_wr",   32'(attr_write),  32'd1);
        chk("resume_addr", 32'(attr_addr),   32'h16);
        chk("resume_data", 32'(attr_wrdata), 32'h4B);
        repeat (9) tick();
        chk("scan_busy_last", 32'(env_busy), 32'd1);
        tick();
        chk("scan_idle", 32'(env_busy), 32'd0);
        repeat (4) tick();

        // Overrun
        chk("ovr_clear", 32'(env_overrun), 32'd0);
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (4) tick();
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        chk("ovr_set", 32'(env_overrun), 32'd1);
        repeat (30) tick();
        chk("ovr_sticky", 32'(env_overrun), 32'd1);
        chk("ovr_idle",   32'(env_busy),    32'd0);

        // Reset mid-scan
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("mrst_write",   32'(attr_write),  32'd0);
        chk("mrst_busy",    32'(env_busy),    32'd0);
        chk("mrst_overrun", 32'(env_overrun), 32'd0);
        wr_cnt = 0;
        sample_run(20);
        chk("mrst_no_env", 32'(wr_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
